// File: rtl/iopmp_dma_initiator_pkg.sv
// Shared types for the IOPMP DMA initiator: initiator FSM states,
// AXI response codes and the NSAID-extended AXI request/response bundles.
package iopmp_dma_initiator_pkg;

    localparam int AXI_ADDR_W  = 64;
    localparam int AXI_DATA_W  = 64;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_NSAID_W = 8;
    localparam int AXI_STRB_W  = AXI_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } init_state_e;

    // AW and AR share one layout; atop is simply tied off on AR.
    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic                   lock;
        logic [3:0]             cache;
        logic [2:0]             prot;
        logic [3:0]             qos;
        logic [3:0]             region;
        logic [5:0]             atop;
        logic                   user;
        logic [AXI_NSAID_W-1:0] nsaid;
    } axi_ax_nsaid_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
        logic                  user;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
        logic                user;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic                  user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_nsaid_t aw;
        logic          aw_valid;
        axi_w_t        w;
        logic          w_valid;
        logic          b_ready;
        axi_ax_nsaid_t ar;
        logic          ar_valid;
        logic          r_ready;
    } axi_req_nsaid_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_rsp_t;

endpackage

// File: rtl/iopmp_dma_initiator.sv
// Single-outstanding AXI4 master issuing NSAID-tagged single-beat
// reads/writes on behalf of a DMA agent; every output is a flop.
module iopmp_dma_initiator
    import iopmp_dma_initiator_pkg::*;
#(
    parameter int          ADDR_WIDTH  = AXI_ADDR_W,
    parameter int          DATA_WIDTH  = AXI_DATA_W,
    parameter int          ID_WIDTH    = AXI_ID_W,
    parameter int          NSAID_WIDTH = AXI_NSAID_W,
    parameter int unsigned TXN_ID      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    input  logic [NSAID_WIDTH-1:0]  cmd_nsaid_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_err_o,
    output logic [15:0]             err_cnt_o,
    output axi_req_nsaid_t          req_o,
    input  axi_rsp_t                rsp_i
);

    init_state_e             state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    r_ready_q, r_ready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [NSAID_WIDTH-1:0]  nsaid_q, nsaid_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic aw_hs, w_hs, aw_fin, w_fin;
    logic unused_rsp;

    assign aw_hs  = aw_valid_q & rsp_i.aw_ready;
    assign w_hs   = w_valid_q & rsp_i.w_ready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    assign unused_rsp = ^{rsp_i.b.id, rsp_i.b.user,
                          rsp_i.r.id, rsp_i.r.last, rsp_i.r.user};

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        nsaid_d     = nsaid_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    nsaid_d     = cmd_nsaid_i;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write_i) begin
                        state_d    = S_WR_ADDR_DATA;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = S_RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR_DATA: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d   = S_WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (rsp_i.b_valid) begin
                    state_d     = S_DONE;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    resp_d      = rsp_i.b.resp;
                end
            end
            S_RD_ADDR: begin
                if (rsp_i.ar_ready) begin
                    state_d    = S_RD_DATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                // A beat with r.last low is still taken as the only beat.
                if (rsp_i.r_valid) begin
                    state_d     = S_DONE;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rsp_i.r.data;
                    resp_d      = rsp_i.r.resp;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Count on entry to DONE so each completion is counted once.
        if (state_q != S_DONE && state_d == S_DONE && resp_d[1]
            && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            nsaid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            nsaid_q     <= nsaid_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        req_o          = '0;
        req_o.aw.id    = ID_WIDTH'(TXN_ID);
        req_o.aw.addr  = addr_q;
        req_o.aw.size  = 3'($clog2(DATA_WIDTH / 8));
        req_o.aw.burst = AXI_BURST_INCR;
        req_o.aw.nsaid = nsaid_q;
        req_o.aw_valid = aw_valid_q;
        req_o.w.data   = wdata_q;
        req_o.w.strb   = wstrb_q;
        req_o.w.last   = 1'b1;
        req_o.w_valid  = w_valid_q;
        req_o.b_ready  = b_ready_q;
        req_o.ar.id    = ID_WIDTH'(TXN_ID);
        req_o.ar.addr  = addr_q;
        req_o.ar.size  = 3'($clog2(DATA_WIDTH / 8));
        req_o.ar.burst = AXI_BURST_INCR;
        req_o.ar.nsaid = nsaid_q;
        req_o.ar_valid = ar_valid_q;
        req_o.r_ready  = r_ready_q;
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
    assign rsp_err_o   = resp_q[1];
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_iopmp_dma_initiator.sv
// Directed bench for iopmp_dma_initiator: vector table of single
// transactions plus backpressure, hold and mid-transaction reset sequences.
module tb_iopmp_dma_initiator;
    import iopmp_dma_initiator_pkg::*;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           cmd_valid_i = 1'b0;
    logic           cmd_ready_o;
    logic           cmd_write_i = 1'b0;
    logic [63:0]    cmd_addr_i = '0;
    logic [63:0]    cmd_wdata_i = '0;
    logic [7:0]     cmd_wstrb_i = '0;
    logic [7:0]     cmd_nsaid_i = '0;
    logic           rsp_valid_o;
    logic           rsp_ready_i = 1'b0;
    logic [63:0]    rsp_rdata_o;
    logic [1:0]     rsp_resp_o;
    logic           rsp_err_o;
    logic [15:0]    err_cnt_o;
    axi_req_nsaid_t req_o;
    axi_rsp_t       rsp_i;

    logic          aw_ready_tb = 1'b1;
    logic          w_ready_tb = 1'b1;
    logic          ar_ready_tb = 1'b1;
    logic          b_hold = 1'b0;
    logic [1:0]    slv_resp = 2'd0;
    logic [63:0]   slv_rdata = '0;
    logic          slv_rlast = 1'b1;
    logic          aw_seen, w_seen, b_valid_s, r_valid_s;
    axi_ax_nsaid_t cap_aw, cap_ar;
    axi_w_t        cap_w;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iopmp_dma_initiator dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_wstrb_i (cmd_wstrb_i),
        .cmd_nsaid_i (cmd_nsaid_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_resp_o  (rsp_resp_o),
        .rsp_err_o   (rsp_err_o),
        .err_cnt_o   (err_cnt_o),
        .req_o       (req_o),
        .rsp_i       (rsp_i)
    );

    // Registered downstream slave: B one cycle after AW+W, R one after AR.
    always @(posedge clk) begin
        if (rst_i) begin
            aw_seen   <= 1'b0;
            w_seen    <= 1'b0;
            b_valid_s <= 1'b0;
            r_valid_s <= 1'b0;
        end else begin
            if (req_o.aw_valid && aw_ready_tb) begin
                aw_seen <= 1'b1;
                cap_aw  <= req_o.aw;
            end
            if (req_o.w_valid && w_ready_tb) begin
                w_seen <= 1'b1;
                cap_w  <= req_o.w;
            end
            if (b_valid_s && req_o.b_ready) begin
                b_valid_s <= 1'b0;
            end else if (!b_valid_s && !b_hold
                         && (aw_seen || (req_o.aw_valid && aw_ready_tb))
                         && (w_seen || (req_o.w_valid && w_ready_tb))) begin
                b_valid_s <= 1'b1;
                aw_seen   <= 1'b0;
                w_seen    <= 1'b0;
            end
            if (req_o.ar_valid && ar_ready_tb) begin
                r_valid_s <= 1'b1;
                cap_ar    <= req_o.ar;
            end else if (r_valid_s && req_o.r_ready) begin
                r_valid_s <= 1'b0;
            end
        end
    end

    always_comb begin
        rsp_i          = '0;
        rsp_i.aw_ready = aw_ready_tb;
        rsp_i.w_ready  = w_ready_tb;
        rsp_i.ar_ready = ar_ready_tb;
        rsp_i.b_valid  = b_valid_s;
        rsp_i.b.resp   = slv_resp;
        rsp_i.r_valid  = r_valid_s;
        rsp_i.r.data   = slv_rdata;
        rsp_i.r.resp   = slv_resp;
        rsp_i.r.last   = slv_rlast;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         input logic [7:0] nsaid);
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_wstrb_i = strb;
        cmd_nsaid_i = nsaid;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid_o), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready_o), 64'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [7:0]  nsaid;
        logic [1:0]  sresp;
        logic [63:0] srdata;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        vecs[0] = '{1'b1, 64'h8000_0010, 64'hDEAD_BEEF, 8'hFF, 8'd3,
                    2'd0, 64'h0, 64'h0, 2'd0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 64'h8000_0020, 64'h0, 8'h00, 8'd5,
                    2'd0, 64'h1234, 64'h1234, 2'd0, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 64'h8000_0100, 64'h0, 8'h00, 8'd7,
                    2'd2, 64'hAAAA, 64'hAAAA, 2'd2, 1'b1, 16'd1};
        vecs[3] = '{1'b1, 64'h9000_0008, 64'h1111_2222, 8'h0F, 8'd9,
                    2'd3, 64'h0, 64'h0, 2'd3, 1'b1, 16'd2};
        vecs[4] = '{1'b0, 64'h0000_0040, 64'h0, 8'h00, 8'hFF,
                    2'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 16'd2};
        vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hCAFE, 8'hF0, 8'd0,
                    2'd1, 64'h0, 64'h0, 2'd1, 1'b0, 16'd2};
        vecs[6] = '{1'b0, 64'h8000_0200, 64'h0, 8'h00, 8'd2,
                    2'd3, 64'h7777, 64'h7777, 2'd3, 1'b1, 16'd3};
        vecs[7] = '{1'b1, 64'h8000_0300, 64'h5A5A, 8'h01, 8'd4,
                    2'd0, 64'h9999, 64'h0, 2'd0, 1'b0, 16'd3};

        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rdata", rsp_rdata_o, 64'd0);
        check("rst_resp", 64'(rsp_resp_o), 64'd0);
        check("rst_err", 64'(rsp_err_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_valids", 64'({req_o.aw_valid, req_o.w_valid,
              req_o.ar_valid, req_o.b_ready, req_o.r_ready}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            slv_resp  = vecs[i].sresp;
            slv_rdata = vecs[i].srdata;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].strb, vecs[i].nsaid);
            wait_rsp(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_rdata", i), rsp_rdata_o, vecs[i].exp_rdata);
            check($sformatf("v%0d_resp", i), 64'(rsp_resp_o),
                  64'(vecs[i].exp_resp));
            check($sformatf("v%0d_err", i), 64'(rsp_err_o),
                  64'(vecs[i].exp_err));
            check($sformatf("v%0d_err_cnt", i), 64'(err_cnt_o),
                  64'(vecs[i].exp_cnt));
            if (vecs[i].wr) begin
                check($sformatf("v%0d_aw_addr", i), cap_aw.addr, vecs[i].addr);
                check($sformatf("v%0d_aw_nsaid", i), 64'(cap_aw.nsaid),
                      64'(vecs[i].nsaid));
                check($sformatf("v%0d_aw_fixed", i),
                      64'({cap_aw.len, cap_aw.size, cap_aw.burst, cap_aw.id}),
                      64'({8'd0, 3'd3, 2'b01, 4'd0}));
                check($sformatf("v%0d_w_data", i), cap_w.data, vecs[i].wdata);
                check($sformatf("v%0d_w_strb_last", i),
                      64'({cap_w.strb, cap_w.last}),
                      64'({vecs[i].strb, 1'b1}));
            end else begin
                check($sformatf("v%0d_ar_addr", i), cap_ar.addr, vecs[i].addr);
                check($sformatf("v%0d_ar_nsaid", i), 64'(cap_ar.nsaid),
                      64'(vecs[i].nsaid));
                check($sformatf("v%0d_ar_fixed", i),
                      64'({cap_ar.len, cap_ar.size, cap_ar.burst, cap_ar.id}),
                      64'({8'd0, 3'd3, 2'b01, 4'd0}));
            end
            consume();
        end

        // AW stalled while W goes through first.
        slv_resp    = 2'd0;
        aw_ready_tb = 1'b0;
        issue(1'b1, 64'h8000_0400, 64'h4242, 8'hFF, 8'd6);
        check("stall_both_valid", 64'({req_o.aw_valid, req_o.w_valid}),
              64'd3);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_c%0d", k),
                  64'({req_o.aw_valid, req_o.w_valid, req_o.b_ready}),
                  64'b100);
            check($sformatf("stall_addr_c%0d", k), req_o.aw.addr,
                  64'h8000_0400);
        end
        aw_ready_tb = 1'b1;
        @(posedge clk);
        #1;
        check("stall_aw_done",
              64'({req_o.aw_valid, req_o.w_valid, req_o.b_ready}), 64'b001);
        wait_rsp(lat);
        check("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("stall_resp", 64'(rsp_resp_o), 64'd0);
        consume();

        // Response held off for 5 cycles.
        slv_rdata = 64'h5555;
        issue(1'b0, 64'h8000_0500, 64'h0, 8'h00, 8'd1);
        wait_rsp(lat);
        check("hold_latency", 64'(lat), 64'd3);
        slv_rdata = 64'h6666;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_c%0d", k),
                  64'({rsp_valid_o, cmd_ready_o, req_o.aw_valid,
                       req_o.w_valid, req_o.ar_valid}), 64'b10000);
            check($sformatf("hold_rdata_c%0d", k), rsp_rdata_o, 64'h5555);
        end
        consume();

        // Reset while waiting for B.
        b_hold = 1'b1;
        issue(1'b1, 64'h8000_0600, 64'h1, 8'h01, 8'd8);
        lat = 0;
        while (!req_o.b_ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("wr_resp_reached", 64'(req_o.b_ready), 64'd1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i  = 1'b0;
        b_hold = 1'b0;
        check("midrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("midrst_valids", 64'({req_o.aw_valid, req_o.w_valid,
              req_o.ar_valid, req_o.b_ready, req_o.r_ready, rsp_valid_o}),
              64'd0);

        // Post-reset read whose only beat has r.last low.
        slv_resp  = 2'd2;
        slv_rdata = 64'hBEEF;
        slv_rlast = 1'b0;
        issue(1'b0, 64'h8000_0700, 64'h0, 8'h00, 8'd3);
        wait_rsp(lat);
        check("nolast_latency", 64'(lat), 64'd3);
        check("nolast_rdata", rsp_rdata_o, 64'hBEEF);
        check("nolast_err_cnt", 64'(err_cnt_o), 64'd1);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
